// File: rtl/jtag_scan_sequencer.sv
// jtag_scan_sequencer: host-side JTAG master. Walks an attached TAP through
// reset, IR/DR scans and Run-Test/Idle cycles, generating TCK/TMS/TDI and
// capturing TDO. The TAP is always parked in RUN_TEST_IDLE between commands.
module jtag_scan_sequencer #(
  parameter int DATA_W  = 32,
  parameter int LEN_W   = 6,
  parameter int CLK_DIV = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              done,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              busy,
  output logic              TCK,
  output logic              TMS,
  output logic              TDI,
  input  logic              TDO
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int PH_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  // Bit counter is one bit wider than cmd_len so len=DATA_W never wraps.
  typedef logic [LEN_W:0] cnt_t;
  typedef logic [PH_W-1:0] ph_t;

  typedef enum logic [2:0] {
    INIT_RST,
    IDLE,
    PRE,
    SHIFT,
    POST,
    RUN,
    FIN
  } state_t;

  localparam logic [1:0] OP_RESET = 2'd0;
  localparam logic [1:0] OP_IR    = 2'd1;
  localparam logic [1:0] OP_DR    = 2'd2;
  localparam logic [1:0] OP_IDLE  = 2'd3;

  localparam ph_t PH_LAST = ph_t'(CLK_DIV - 1);

  state_t              state_q, state_d;
  ph_t                 phase_q, phase_d;
  logic                half_q, half_d;      // 0 = TCK low phase, 1 = high phase
  cnt_t                idx_q, idx_d;        // bit index within current state
  logic                tck_q, tck_d;
  logic                tms_q, tms_d;
  logic                tdi_q, tdi_d;
  logic [1:0]          op_q, op_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                rsp_err_q, rsp_err_d;
  logic                cmd_seen_q, cmd_seen_d; // INIT_RST ends in FIN once a command ran

  state_t              nxt_state;
  cnt_t                nxt_idx;
  logic                step;
  cnt_t                cmd_len_ext;
  cnt_t                len_ext;
  logic                len_bad;

  // TMS value to present for bit 'idx' of state 'st'.
  function automatic logic tms_val(input state_t st, input cnt_t idx,
                                   input logic is_ir, input cnt_t len);
    logic r;
    r = 1'b0;
    case (st)
      INIT_RST: r = (idx < cnt_t'(5));                  // 1,1,1,1,1,0
      PRE:      r = is_ir ? (idx < cnt_t'(2))           // 1,1,0,0
                          : (idx < cnt_t'(1));          // 1,0,0
      SHIFT:    r = ((idx + cnt_t'(1)) == len);         // exit on last bit
      POST:     r = (idx == cnt_t'(0));                 // 1,0
      default:  r = 1'b0;
    endcase
    return r;
  endfunction

  // State and datapath registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= INIT_RST;
      phase_q    <= '0;
      half_q     <= 1'b0;
      idx_q      <= '0;
      tck_q      <= 1'b0;
      tms_q      <= 1'b1;
      tdi_q      <= 1'b0;
      op_q       <= OP_RESET;
      len_q      <= '0;
      data_q     <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      cmd_seen_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      half_q     <= half_d;
      idx_q      <= idx_d;
      tck_q      <= tck_d;
      tms_q      <= tms_d;
      tdi_q      <= tdi_d;
      op_q       <= op_d;
      len_q      <= len_d;
      data_q     <= data_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      cmd_seen_q <= cmd_seen_d;
    end
  end

  // Next-state logic: command accept, TCK phase timing, bit sequencing.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    half_d     = half_q;
    idx_d      = idx_q;
    tck_d      = tck_q;
    tms_d      = tms_q;
    tdi_d      = tdi_q;
    op_d       = op_q;
    len_d      = len_q;
    data_d     = data_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    cmd_seen_d = cmd_seen_q;

    nxt_state   = state_q;
    nxt_idx     = '0;
    step        = 1'b0;
    cmd_len_ext = {1'b0, cmd_len};
    len_ext     = {1'b0, len_q};
    len_bad     = (cmd_len_ext == cnt_t'(0)) || (cmd_len_ext > cnt_t'(DATA_W));

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          op_d       = cmd_op;
          len_d      = cmd_len;
          data_d     = cmd_data;
          rsp_data_d = '0;
          rsp_err_d  = 1'b0;
          cmd_seen_d = 1'b1;
          step       = 1'b1;
          case (cmd_op)
            OP_RESET: nxt_state = INIT_RST;
            OP_IR, OP_DR: begin
              if (len_bad) begin
                nxt_state = FIN;
                rsp_err_d = 1'b1;
              end else begin
                nxt_state = PRE;
              end
            end
            default: nxt_state = (cmd_len_ext == cnt_t'(0)) ? FIN : RUN;
          endcase
        end
      end

      FIN: begin
        nxt_state = IDLE;
        step      = 1'b1;
      end

      default: begin
        // A bit is in progress: CLK_DIV cycles low, then CLK_DIV cycles high.
        if (phase_q != PH_LAST) begin
          phase_d = phase_q + ph_t'(1);
        end else if (!half_q) begin
          phase_d = '0;
          half_d  = 1'b1;
          tck_d   = 1'b1;
          if (state_q == SHIFT) begin
            rsp_data_d[idx_q[IDX_W-1:0]] = TDO;
          end
        end else begin
          step    = 1'b1;
          nxt_idx = idx_q + cnt_t'(1);
          case (state_q)
            INIT_RST: begin
              if (idx_q == cnt_t'(5)) begin
                nxt_state = cmd_seen_q ? FIN : IDLE;
                nxt_idx   = '0;
              end
            end
            PRE: begin
              if (idx_q == ((op_q == OP_IR) ? cnt_t'(3) : cnt_t'(2))) begin
                nxt_state = SHIFT;
                nxt_idx   = '0;
              end
            end
            SHIFT: begin
              if ((idx_q + cnt_t'(1)) == len_ext) begin
                nxt_state = POST;
                nxt_idx   = '0;
              end
            end
            POST: begin
              if (idx_q == cnt_t'(1)) begin
                nxt_state = FIN;
                nxt_idx   = '0;
              end
            end
            RUN: begin
              if ((idx_q + cnt_t'(1)) == len_ext) begin
                nxt_state = FIN;
                nxt_idx   = '0;
              end
            end
            default: begin
              nxt_state = IDLE;
              nxt_idx   = '0;
            end
          endcase
        end
      end
    endcase

    // Start of a new bit (or leaving the bit states): TCK goes low and
    // TMS/TDI take their values for the next bit at the same edge.
    if (step) begin
      state_d = nxt_state;
      idx_d   = nxt_idx;
      phase_d = '0;
      half_d  = 1'b0;
      tck_d   = 1'b0;
      tms_d   = tms_val(nxt_state, nxt_idx, (op_d == OP_IR), {1'b0, len_d});
      tdi_d   = (nxt_state == SHIFT) ? data_d[nxt_idx[IDX_W-1:0]] : 1'b0;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = ~cmd_ready;
  assign done      = (state_q == FIN);
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign TCK       = tck_q;
  assign TMS       = tms_q;
  assign TDI       = tdi_q;

endmodule

// File: tb/tb_jtag_scan_sequencer.sv
// Directed bench for jtag_scan_sequencer with a behavioural TAP model and
// a scoreboard of expected command responses.
module tb_jtag_scan_sequencer;

  localparam int DATA_W  = 32;
  localparam int LEN_W   = 6;
  localparam int CLK_DIV = 2;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [1:0]        cmd_op = 2'd0;
  logic [LEN_W-1:0]  cmd_len = '0;
  logic [DATA_W-1:0] cmd_data = '0;
  logic              done;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
  logic              busy;
  logic              TCK, TMS, TDI, TDO;

  jtag_scan_sequencer #(.DATA_W(DATA_W), .LEN_W(LEN_W), .CLK_DIV(CLK_DIV)) dut (
    .CLK(CLK), .RST(RST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_len(cmd_len), .cmd_data(cmd_data),
    .done(done), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
    .TCK(TCK), .TMS(TMS), .TDI(TDI), .TDO(TDO)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // ---------------- TAP model ----------------
  typedef enum logic [3:0] {
    T_TLR, T_RTI, T_SELDR, T_CAPDR, T_SHDR, T_EX1DR, T_PDR, T_EX2DR, T_UPDR,
    T_SELIR, T_CAPIR, T_SHIR, T_EX1IR, T_PIR, T_EX2IR, T_UPIR
  } tap_t;

  tap_t        tap_st = T_TLR;
  logic [3:0]  ir_sr = 4'h0;
  logic [3:0]  tap_ir = 4'h0;
  logic [31:0] dr_sr = 32'h0;
  logic        tap_tdo = 1'b0;
  bit          loopback = 1'b0;

  assign TDO = loopback ? TDI : tap_tdo;

  function automatic tap_t tap_next(input tap_t s, input logic m);
    case (s)
      T_TLR:   return m ? T_TLR   : T_RTI;
      T_RTI:   return m ? T_SELDR : T_RTI;
      T_SELDR: return m ? T_SELIR : T_CAPDR;
      T_CAPDR: return m ? T_EX1DR : T_SHDR;
      T_SHDR:  return m ? T_EX1DR : T_SHDR;
      T_EX1DR: return m ? T_UPDR  : T_PDR;
      T_PDR:   return m ? T_EX2DR : T_PDR;
      T_EX2DR: return m ? T_UPDR  : T_SHDR;
      T_UPDR:  return m ? T_SELDR : T_RTI;
      T_SELIR: return m ? T_TLR   : T_CAPIR;
      T_CAPIR: return m ? T_EX1IR : T_SHIR;
      T_SHIR:  return m ? T_EX1IR : T_SHIR;
      T_EX1IR: return m ? T_UPIR  : T_PIR;
      T_PIR:   return m ? T_EX2IR : T_PIR;
      T_EX2IR: return m ? T_UPIR  : T_SHIR;
      default: return m ? T_SELDR : T_RTI;
    endcase
  endfunction

  always @(posedge TCK) begin
    case (tap_st)
      T_CAPIR: ir_sr  <= 4'b0001;
      T_SHIR:  ir_sr  <= {TDI, ir_sr[3:1]};
      T_UPIR:  tap_ir <= ir_sr;
      T_CAPDR: dr_sr  <= 32'h1234_5678;
      T_SHDR:  dr_sr  <= {TDI, dr_sr[31:1]};
      default: ;
    endcase
    tap_st <= tap_next(tap_st, TMS);
  end

  always @(negedge TCK)
    tap_tdo <= (tap_st == T_SHIR) ? ir_sr[0] : (tap_st == T_SHDR) ? dr_sr[0] : 1'b0;

  // ---------------- pin monitors ----------------
  int          tck_cnt = 0;
  logic [63:0] tms_vec = '0;
  logic [63:0] tdi_vec = '0;
  int          acc_cnt = 0;
  int          done_cnt = 0;
  int          hi_run = 0;
  int          bad_timing = 0;

  always @(posedge TCK) begin
    if (tck_cnt < 64) begin
      tms_vec[tck_cnt] = TMS;
      tdi_vec[tck_cnt] = TDI;
    end
    tck_cnt = tck_cnt + 1;
  end

  always @(posedge CLK)
    if (cmd_valid && cmd_ready) acc_cnt = acc_cnt + 1;

  // Each TCK high phase must last exactly CLK_DIV clocks.
  always @(negedge CLK) begin
    if (done) done_cnt = done_cnt + 1;
    if (RST) hi_run = 0;
    else if (TCK) hi_run = hi_run + 1;
    else begin
      if (hi_run != 0 && hi_run != CLK_DIV) bad_timing = bad_timing + 1;
      hi_run = 0;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [31:0] data;
    logic        err;
    int          ntck;
    logic [63:0] tms;
    logic [63:0] tdi;
  } exp_t;

  exp_t sb_q[$];

  function automatic logic [63:0] exp_tms(input int op, input int len);
    logic [63:0] v;
    v = '0;
    case (op)
      0: for (int k = 0; k < 5; k++) v[k] = 1'b1;
      1: begin v[0] = 1'b1; v[1] = 1'b1; v[4 + len - 1] = 1'b1; v[4 + len] = 1'b1; end
      2: begin v[0] = 1'b1; v[3 + len - 1] = 1'b1; v[3 + len] = 1'b1; end
      default: ;
    endcase
    return v;
  endfunction

  function automatic logic [63:0] exp_tdi(input int op, input int len, input logic [31:0] d);
    logic [63:0] v;
    int pre;
    v = '0;
    pre = (op == 1) ? 4 : 3;
    if (op == 1 || op == 2)
      for (int k = 0; k < len; k++) v[pre + k] = d[k];
    return v;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ready(input int limit, output int cyc);
    cyc = 0;
    while (!cmd_ready && cyc < limit) begin
      @(negedge CLK);
      cyc++;
    end
  endtask

  task automatic run_cmd(input logic [1:0] op, input int len, input logic [31:0] data,
                         input logic [31:0] exp_rsp, input logic exp_err,
                         input bit hold, output int cyc);
    exp_t e;
    exp_t g;
    int   w;
    bit   legal;
    bit   got;
    legal  = (op == 2'd0) || (op == 2'd3) || (len >= 1 && len <= DATA_W);
    e.data = exp_rsp;
    e.err  = exp_err;
    e.ntck = !legal ? 0 : (op == 2'd0) ? 6 : (op == 2'd1) ? len + 6 : (op == 2'd2) ? len + 5 : len;
    e.tms  = legal ? exp_tms(op, len) : '0;
    e.tdi  = legal ? exp_tdi(op, len, data) : '0;
    wait_ready(200, w);
    if (!cmd_ready) check("ready_timeout", 64'd0, 64'd1);
    tck_cnt = 0; tms_vec = '0; tdi_vec = '0; acc_cnt = 0;
    sb_q.push_back(e);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_len   = len[LEN_W-1:0];
    cmd_data  = data;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 500) begin
      @(negedge CLK);
      cyc++;
      if (!hold) cmd_valid = 1'b0;
      if (done) got = 1'b1;
    end
    cmd_valid = 1'b0;
    if (!got) begin
      check("done_timeout", 64'd0, 64'd1);
      void'(sb_q.pop_front());
    end else begin
      g = sb_q.pop_front();
      check("rsp_data", 64'(rsp_data), 64'(g.data));
      check("rsp_err", 64'(rsp_err), 64'(g.err));
      check("tck_count", 64'(tck_cnt), 64'(g.ntck));
      check("tms_seq", tms_vec, g.tms);
      check("tdi_seq", tdi_vec, g.tdi);
      check("accept_count", 64'(acc_cnt), 64'd1);
      check("tap_in_rti", 64'(tap_st), 64'(T_RTI));
      @(negedge CLK);
      check("ready_after_done", 64'({cmd_ready, busy, done}), 64'b100);
      check("rsp_held", 64'({rsp_err, rsp_data}), 64'({g.err, g.data}));
    end
    $display("cmd op=%0d len=%0d data=0x%08h -> rsp=0x%08h err=%0b tck=%0d cycles=%0d",
             op, len, data, rsp_data, rsp_err, tck_cnt, cyc);
  endtask

  task automatic check_init(input string tag);
    int cyc;
    wait_ready(100, cyc);
    check({tag, "_cycles"}, 64'(cyc), 64'(6 * 2 * CLK_DIV));
    check({tag, "_tck"}, 64'(tck_cnt), 64'd6);
    check({tag, "_tms"}, tms_vec, 64'h1F);
    check({tag, "_tdi"}, tdi_vec, 64'h0);
    check({tag, "_tap_rti"}, 64'(tap_st), 64'(T_RTI));
    $display("init %s: ready after %0d cycles, tck=%0d", tag, cyc, tck_cnt);
  endtask

  initial begin
    int cyc;
    int w;
    int dc;

    // Reset state
    repeat (3) @(negedge CLK);
    check("reset_pins", 64'({TCK, TMS, TDI}), 64'b010);
    check("reset_ctrl", 64'({cmd_ready, busy, done, rsp_err}), 64'b0100);
    check("reset_rsp", 64'(rsp_data), 64'd0);
    tck_cnt = 0; tms_vec = '0; tdi_vec = '0;
    RST = 1'b0;
    check_init("init");

    // IR scan through the TAP model
    run_cmd(2'd1, 4, 32'hA, 32'h1, 1'b0, 1'b0, cyc);
    check("tap_ir", 64'(tap_ir), 64'hA);

    // Full-width DR scan with TDO looped to TDI, cmd_valid held high
    loopback = 1'b1;
    run_cmd(2'd2, 32, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b1, cyc);
    loopback = 1'b0;

    // Run-Test/Idle cycles
    run_cmd(2'd3, 3, 32'h0, 32'h0, 1'b0, 1'b0, cyc);
    run_cmd(2'd3, 0, 32'h0, 32'h0, 1'b0, 1'b0, cyc);
    check("idle0_latency", 64'(cyc), 64'd1);

    // Illegal scan lengths
    run_cmd(2'd2, 0, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, cyc);
    check("len0_latency", 64'(cyc), 64'd1);
    run_cmd(2'd2, 33, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, cyc);
    check("len33_latency", 64'(cyc), 64'd1);

    // RESET op
    run_cmd(2'd0, 0, 32'h0, 32'h0, 1'b0, 1'b0, cyc);

    // Reset asserted during shift bit 10 of a DR scan
    wait_ready(200, w);
    tck_cnt = 0;
    cmd_valid = 1'b1; cmd_op = 2'd2; cmd_len = 6'd20; cmd_data = 32'h000F_0F0F;
    @(negedge CLK);
    cmd_valid = 1'b0;
    w = 0;
    while (tck_cnt < 3 + 10 + 1 && w < 500) begin
      @(negedge CLK);
      w++;
    end
    check("abort_reached_bit10", 64'(tck_cnt), 64'd14);
    dc = done_cnt;
    RST = 1'b1;
    #1;
    check("abort_pins", 64'({TCK, TMS}), 64'b01);
    check("abort_ctrl", 64'({cmd_ready, done}), 64'b00);
    repeat (2) @(negedge CLK);
    tck_cnt = 0; tms_vec = '0; tdi_vec = '0;
    RST = 1'b0;
    check_init("reinit");
    check("abort_no_done", 64'(done_cnt), 64'(dc));
    $display("abort at shift bit 10: done pulses during abort=%0d", done_cnt - dc);

    // Scan after recovery, data from TAP DR capture
    run_cmd(2'd2, 8, 32'h5A, 32'h78, 1'b0, 1'b0, cyc);

    check("tck_high_timing", 64'(bad_timing), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
